// File: rtl/tp_mem_wr_packer.sv
// tp_mem_wr_packer: packs DIN_W-bit beats into WORD_W-bit memory words and
// issues one write per completed word at an auto-incrementing, wrapping address.
// Optional feature macro: TP_PACK_FLUSH_EN adds a flush input that writes out a
// partial word (unfilled segments zero) and ends the transfer early.
module tp_mem_wr_packer #(
    parameter int unsigned DIN_W  = 64,
    parameter int unsigned WORD_W = 1024,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_data,
`ifdef TP_PACK_FLUSH_EN
    input  logic              flush,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_word,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BEATS = WORD_W / DIN_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LAST
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W:0]     remaining;
    logic [CNT_W-1:0]    beat_cnt;
    logic [WORD_W-1:0]   assemble;
    logic [WORD_W-1:0]   merged;
    logic                done_zero;
    logic                accept;
    logic                word_done;
    logic                flush_req;

`ifdef TP_PACK_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign accept    = in_valid && in_ready;
    assign word_done = accept && (beat_cnt == LAST_BEAT);

    // Assembly buffer with the beat of this cycle (if any) dropped into its slot.
    always_comb begin
        merged = assemble;
        if (accept) begin
            merged[DIN_W*beat_cnt +: DIN_W] = in_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start && (num_words != '0)) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if ((word_done && (remaining == (ADDR_W+1)'(1))) || flush_req) begin
                    next_state = LAST;
                end
            end
            LAST: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM outputs; done also covers the zero-length transfer, which never leaves IDLE.
    always_comb begin
        in_ready = (state == FILL);
        busy     = (state != IDLE);
        done     = (state == LAST) || done_zero;
    end

    // Counters, assembly buffer and registered write port.
    // The buffer is cleared after every write so a flushed partial word has zeros
    // in the segments that were never filled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            beat_cnt  <= '0;
            assemble  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_word   <= '0;
            done_zero <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            done_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= num_words;
                        beat_cnt  <= '0;
                        assemble  <= '0;
                        done_zero <= (num_words == '0);
                    end
                end
                FILL: begin
                    if (word_done) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= addr;
                        wr_word   <= merged;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        beat_cnt  <= '0;
                        assemble  <= '0;
                    end else if (flush_req && (accept || (beat_cnt != '0))) begin
                        wr_en     <= 1'b1;
                        wr_addr   <= addr;
                        wr_word   <= merged;
                        beat_cnt  <= '0;
                        assemble  <= '0;
                    end else if (accept) begin
                        assemble  <= merged;
                        beat_cnt  <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tp_mem_wr_packer.sv
// Self-checking bench for tp_mem_wr_packer: a reference model of the packer
// pushes expected {address, word} writes into a queue as beats are accepted;
// every DUT write pops and compares one entry.
module tb_tp_mem_wr_packer;

    localparam int DIN_W  = 64;
    localparam int WORD_W = 1024;
    localparam int ADDR_W = 6;
    localparam int BEATS  = WORD_W / DIN_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic              in_valid;
    logic              in_ready;
    logic [DIN_W-1:0]  in_data;
`ifdef TP_PACK_FLUSH_EN
    logic              flush;
`endif
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_word;
    logic              busy;
    logic              done;

    tp_mem_wr_packer #(
        .DIN_W (DIN_W),
        .WORD_W(WORD_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .num_words(num_words),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef TP_PACK_FLUSH_EN
        .flush    (flush),
`endif
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_word  (wr_word),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } exp_t;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                last_wr_cyc = -1000;
    int                last_done_cyc = -1000;
    int                done_cnt = 0;
    int                wr_cnt = 0;
    int                g_idx = 0;
    logic [WORD_W-1:0] hold_word;
    logic [WORD_W-1:0] m_word;
    logic [ADDR_W-1:0] m_addr;
    int                m_beat;

    // Advance one clock, sample #1 after the edge, service the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (wr_en) begin
            wr_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: wr_en=1 addr=%0d, required no write", wr_addr);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_word !== e.word) begin
                    n_fail++;
                    $display("FAIL write_data: addr=%0d word=%h, required addr=%0d word=%h",
                             wr_addr, wr_word[255:0], e.addr, e.word[255:0]);
                end
            end
            n_checks++;
            if (cyc - last_wr_cyc < BEATS) begin
                n_fail++;
                $display("FAIL write_spacing: %0d cycles, required >= %0d", cyc - last_wr_cyc, BEATS);
            end
            last_wr_cyc = cyc;
            hold_word = wr_word;
        end else begin
            n_checks++;
            if (wr_word !== hold_word) begin
                n_fail++;
                $display("FAIL word_hold: wr_word changed without wr_en at cycle %0d", cyc);
            end
        end
    endtask

    task automatic begin_transfer(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] nw);
        start     = 1'b1;
        base_addr = base;
        num_words = nw;
        step();
        start     = 1'b0;
        m_addr    = base;
        m_beat    = 0;
        m_word    = '0;
    endtask

    task automatic model_beat(input logic [DIN_W-1:0] d);
        exp_t e;
        m_word[DIN_W*m_beat +: DIN_W] = d;
        m_beat++;
        if (m_beat == BEATS) begin
            e.addr = m_addr;
            e.word = m_word;
            exp_q.push_back(e);
            m_addr = m_addr + 1'b1;
            m_beat = 0;
            m_word = '0;
        end
    endtask

    // Offer beats until n are accepted; gap_pct = chance of in_valid=0 per cycle.
    task automatic send_beats(input int n, input int gap_pct, input bit rnd_data, output int cycles);
        int got;
        int budget;
        got    = 0;
        budget = n * 20 + 50;
        cycles = 0;
        while (got < n && budget > 0) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = rnd_data ? {$urandom, $urandom} : DIN_W'(g_idx);
            if (in_valid && in_ready) begin
                model_beat(in_data);
                got++;
                g_idx++;
            end
            step();
            cycles++;
            budget--;
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        n_checks++;
        if (got != n) begin
            n_fail++;
            $display("FAIL beat_timeout: accepted %0d beats, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_word !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b wr_en=%b wr_addr=%0d busy=%b done=%b, required all 0",
                     in_ready, wr_en, wr_addr, busy, done);
        end
        hold_word = '0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int cycles;
        int d0;
        d0    = done_cnt;
        g_idx = 0;
        begin_transfer(6'd5, 7'd2);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: in_ready=%b busy=%b, required 1 1", in_ready, busy);
        end
        send_beats(32, 0, 1'b0, cycles);
        n_checks++;
        if (cycles != 32) begin
            n_fail++;
            $display("FAIL throughput: %0d cycles for 32 beats, required 32", cycles);
        end
        n_checks++;
        if (last_done_cyc != cyc || last_wr_cyc != cyc || done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL done_with_last_write: done_cyc=%0d wr_cyc=%0d now=%0d, required all equal",
                     last_done_cyc, last_wr_cyc, cyc);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_last: in_ready=%b, required 0", in_ready);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_fall: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_wrap_random();
        int cycles;
        int w0;
        w0 = wr_cnt;
        begin_transfer(6'd63, 7'd3);
        send_beats(48, 30, 1'b1, cycles);
        n_checks++;
        if (wr_cnt != w0 + 3 || last_done_cyc != cyc) begin
            n_fail++;
            $display("FAIL wrap_writes: %0d writes done_cyc=%0d now=%0d, required 3 writes with done now",
                     wr_cnt - w0, last_done_cyc, cyc);
        end
        repeat (2) step();
    endtask

    task automatic test_zero_words();
        begin_transfer(6'd7, 7'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_words: done=%b busy=%b in_ready=%b wr_en=%b, required 1 0 0 0",
                     done, busy, in_ready, wr_en);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_words_after: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_start_while_busy();
        int cycles;
        int w0;
        w0 = wr_cnt;
        begin_transfer(6'd10, 7'd2);
        send_beats(5, 0, 1'b1, cycles);
        start     = 1'b1;
        base_addr = 6'd40;
        num_words = 7'd1;
        send_beats(1, 0, 1'b1, cycles);
        start     = 1'b0;
        send_beats(26, 10, 1'b1, cycles);
        n_checks++;
        if (wr_cnt != w0 + 2 || last_done_cyc != cyc) begin
            n_fail++;
            $display("FAIL start_ignored: %0d writes, required 2 with done on last", wr_cnt - w0);
        end
        repeat (2) step();
    endtask

    task automatic test_reset_abort();
        int cycles;
        begin_transfer(6'd20, 7'd2);
        send_beats(7, 0, 1'b1, cycles);
        rst_n     = 1'b0;
        hold_word = '0;
        step();
        n_checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            wr_addr !== '0 || wr_word !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: in_ready=%b wr_en=%b busy=%b done=%b wr_addr=%0d, required all 0",
                     in_ready, wr_en, busy, done, wr_addr);
        end
        step();
        rst_n  = 1'b1;
        m_beat = 0;
        m_word = '0;
        step();
        begin_transfer(6'd0, 7'd1);
        send_beats(16, 20, 1'b1, cycles);
        n_checks++;
        if (last_wr_cyc != cyc || last_done_cyc != cyc) begin
            n_fail++;
            $display("FAIL fresh_word: wr_cyc=%0d done_cyc=%0d now=%0d, required equal",
                     last_wr_cyc, last_done_cyc, cyc);
        end
        repeat (2) step();
    endtask

`ifdef TP_PACK_FLUSH_EN
    task automatic test_flush();
        int   cycles;
        exp_t e;
        begin_transfer(6'd30, 7'd3);
        g_idx = 10;
        send_beats(3, 0, 1'b0, cycles);
        flush  = 1'b1;
        e.addr = m_addr;
        e.word = m_word;
        exp_q.push_back(e);
        m_word = '0;
        m_beat = 0;
        step();
        flush = 1'b0;
        n_checks++;
        if (last_wr_cyc != cyc || done !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_partial: wr_cyc=%0d now=%0d done=%b, required write and done now",
                     last_wr_cyc, cyc, done);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_end: busy=%b, required 0", busy);
        end
        begin_transfer(6'd40, 7'd2);
        g_idx = 0;
        send_beats(15, 0, 1'b0, cycles);
        in_valid = 1'b1;
        in_data  = 64'd15;
        flush    = 1'b1;
        model_beat(in_data);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (last_wr_cyc != cyc || done !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: wr_cyc=%0d now=%0d done=%b, required write and done now",
                     last_wr_cyc, cyc, done);
        end
        repeat (3) step();
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_full_end: busy=%b in_ready=%b, required 0 0", busy, in_ready);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        in_valid  = 1'b0;
        in_data   = '0;
`ifdef TP_PACK_FLUSH_EN
        flush     = 1'b0;
`endif
        test_reset();
        test_back_to_back();
        test_wrap_random();
        test_zero_words();
        test_start_while_busy();
        test_reset_abort();
`ifdef TP_PACK_FLUSH_EN
        test_flush();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_writes: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
